cursor_shot_ctrl: RTL

- Sequencer between the mouse decoder and the cursor draw stage.
- Clamps raw mouse coordinates to the active area and commits them to the cursor position outputs only at vertical-blank start, so the cursor never tears mid-frame.
- Turns left-button presses into one-shot, valid/ready shot requests to game logic, stamped with the displayed cursor coordinates.
- Enforces a per-shot cooldown measured in frames.

---
 rtl/cursor_shot_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cursor_shot_ctrl.sv
// Cursor position commit at vertical-blank start plus a one-shot, cooldown-limited
// shot request handshake. Define CURSOR_AMMO_EN to add a reloadable ammo counter.
module cursor_shot_ctrl #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 600,
    parameter int COOLDOWN_FRAMES = 15
`ifdef CURSOR_AMMO_EN
    ,
    parameter int AMMO_MAX        = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic        mouse_left,
    input  logic        vblnk,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        shot_valid,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    input  logic        shot_ready,
`ifdef CURSOR_AMMO_EN
    input  logic        reload,
    output logic [1:0]  ammo,
`endif
    output logic        busy
);

    // state        | meaning
    // ST_IDLE      | armed, waiting for a fresh left-button press
    // ST_PENDING   | shot_valid high, waiting for shot_ready
    // ST_COOLDOWN  | counting down frame ticks after an accepted shot
    // ST_WAIT_REL  | cooldown over, button must be released before re-arming
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PENDING  = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    localparam logic [11:0] X_MAX   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE - 1);
    localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

    logic [1:0]  state_q, state_d;
    logic        vblnk_prev_q, vblnk_prev_d;
    logic        left_prev_q, left_prev_d;
    logic [11:0] x_pos_q, x_pos_d;
    logic [11:0] y_pos_q, y_pos_d;
    logic [11:0] shot_x_q, shot_x_d;
    logic [11:0] shot_y_q, shot_y_d;
    logic [7:0]  cd_cnt_q, cd_cnt_d;

    logic frame_tick;
    logic press;
    logic accept;
    logic ammo_ok;

    assign frame_tick = vblnk & ~vblnk_prev_q;
    assign press      = mouse_left & ~left_prev_q;
    assign accept     = (state_q == ST_PENDING) & shot_ready;

`ifdef CURSOR_AMMO_EN
    localparam logic [1:0] AMMO_LOAD = 2'(AMMO_MAX);

    logic [1:0] ammo_q, ammo_d;

    // Reload takes priority over a same-cycle handshake.
    always_comb begin
        ammo_d = ammo_q;
        if (reload) begin
            ammo_d = AMMO_LOAD;
        end else if (accept && (ammo_q != 2'd0)) begin
            ammo_d = ammo_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ammo_q <= AMMO_LOAD;
        end else begin
            ammo_q <= ammo_d;
        end
    end

    assign ammo    = ammo_q;
    assign ammo_ok = (ammo_q != 2'd0);
`else
    assign ammo_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        vblnk_prev_d = vblnk;
        left_prev_d  = mouse_left;
        x_pos_d      = x_pos_q;
        y_pos_d      = y_pos_q;
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        cd_cnt_d     = cd_cnt_q;

        if (frame_tick) begin
            x_pos_d = (mouse_x > X_MAX) ? X_MAX : mouse_x;
            y_pos_d = (mouse_y > Y_MAX) ? Y_MAX : mouse_y;
        end

        case (state_q)
            ST_IDLE: begin
                // Stamp with the displayed position, not the one being committed now.
                if (press && ammo_ok) begin
                    shot_x_d = x_pos_q;
                    shot_y_d = y_pos_q;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (accept) begin
                    cd_cnt_d = CD_LOAD;
                    state_d  = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick) begin
                    cd_cnt_d = cd_cnt_q - 8'd1;
                    if (cd_cnt_q <= 8'd1) begin
                        cd_cnt_d = 8'd0;
                        state_d  = ST_WAIT_REL;
                    end
                end
            end
            ST_WAIT_REL: begin
                if (!mouse_left) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vblnk_prev_q <= 1'b0;
            left_prev_q  <= 1'b0;
            x_pos_q      <= 12'd0;
            y_pos_q      <= 12'd0;
            shot_x_q     <= 12'd0;
            shot_y_q     <= 12'd0;
            cd_cnt_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            vblnk_prev_q <= vblnk_prev_d;
            left_prev_q  <= left_prev_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            cd_cnt_q     <= cd_cnt_d;
        end
    end

    assign x_pos      = x_pos_q;
    assign y_pos      = y_pos_q;
    assign shot_x     = shot_x_q;
    assign shot_y     = shot_y_q;
    assign shot_valid = (state_q == ST_PENDING);
    assign busy       = (state_q != ST_IDLE);

endmodule
